// File: rtl/frame_accumulate_if.sv
// Sample and frame-total channels between the adder stage and frame_accumulate.
// The accumulator is the slave; its feeder and downstream sink form the master side.
interface frame_accumulate_if #(
    parameter int OUT_W = 34
) ();
    logic [31:0]      state__C;
    logic             state__C_vld;
    logic             state__C_rdy;
    logic [OUT_W-1:0] state__D;
    logic             state__D_vld;
    logic             state__D_rdy;

    modport slave (
        input  state__C,
        input  state__C_vld,
        output state__C_rdy,
        output state__D,
        output state__D_vld,
        input  state__D_rdy
    );

    modport master (
        output state__C,
        output state__C_vld,
        input  state__C_rdy,
        input  state__D,
        input  state__D_vld,
        output state__D_rdy
    );
endinterface

// File: rtl/frame_accumulate.sv
// Sums every N accepted 32-bit samples into one registered OUT_W-bit frame total.
// Only the last sample of a frame waits on the output register.
module frame_accumulate #(
    parameter int N     = 4,
    parameter int OUT_W = 34
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    frame_accumulate_if.slave   bus
);
    logic [OUT_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic [OUT_W-1:0] r_d;
    logic             r_d_vld;

    logic             w_last;
    logic             w_out_free;
    logic             w_take;
    logic [OUT_W-1:0] w_sum;

    assign w_last     = (r_cnt == 8'(N - 1));
    assign w_out_free = ~r_d_vld | bus.state__D_rdy;
    // rst gates ready so nothing is offered as accepted while reset is held
    assign w_take     = rst & bus.state__C_vld & ~clear
                      & (~w_last | w_out_free);
    assign w_sum      = r_acc + OUT_W'(bus.state__C);

    assign bus.state__C_rdy = w_take;
    assign bus.state__D     = r_d;
    assign bus.state__D_vld = r_d_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_d_vld <= 1'b0;
        end else begin
            if (clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_take) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            // a new total overrides the drain so back-to-back frames keep valid high
            if (w_take && w_last) begin
                r_d     <= w_sum;
                r_d_vld <= 1'b1;
            end else if (r_d_vld && bus.state__D_rdy) begin
                r_d_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_accumulate.sv
// Directed bench for frame_accumulate: three instances (N=4/34b, N=4/32b, N=1/34b)
// with per-instance expected-total queues drained by output monitors.
module tb_frame_accumulate;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    frame_accumulate_if #(.OUT_W(34)) bA ();
    frame_accumulate_if #(.OUT_W(32)) bB ();
    frame_accumulate_if #(.OUT_W(34)) bC ();

    frame_accumulate #(.N(4), .OUT_W(34)) u_a (
        .clk(clk), .rst(rst), .clear(clr), .bus(bA));
    frame_accumulate #(.N(4), .OUT_W(32)) u_b (
        .clk(clk), .rst(rst), .clear(1'b0), .bus(bB));
    frame_accumulate #(.N(1), .OUT_W(34)) u_c (
        .clk(clk), .rst(rst), .clear(1'b0), .bus(bC));

    int n_chk = 0;
    int n_bad = 0;
    int last_stalls;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] qc[$];

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic mon(input string nm, inout logic [63:0] q[$],
                       input logic [63:0] a);
        logic [63:0] e;
        n_chk++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %0h want nothing", nm, a);
        end else begin
            e = q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %0h want %0h", nm, a, e);
            end
        end
    endtask

    always @(negedge clk)
        if (rst && bA.state__D_vld && bA.state__D_rdy)
            mon("mon_a", qa, 64'(bA.state__D));
    always @(negedge clk)
        if (rst && bB.state__D_vld && bB.state__D_rdy)
            mon("mon_b", qb, 64'(bB.state__D));
    always @(negedge clk)
        if (rst && bC.state__D_vld && bC.state__D_rdy)
            mon("mon_c", qc, 64'(bC.state__D));

    task automatic setc(input int w, input logic [31:0] v, input logic vl);
        case (w)
            0: begin bA.state__C = v; bA.state__C_vld = vl; end
            1: begin bB.state__C = v; bB.state__C_vld = vl; end
            default: begin bC.state__C = v; bC.state__C_vld = vl; end
        endcase
    endtask

    function automatic logic rdyc(input int w);
        case (w)
            0: return bA.state__C_rdy;
            1: return bB.state__C_rdy;
            default: return bC.state__C_rdy;
        endcase
    endfunction

    // offer one sample; returns at posedge+1 after the accepting edge
    task automatic put(input int w, input logic [31:0] v);
        int  st;
        logic ok;
        st = 0;
        ok = 1'b0;
        setc(w, v, 1'b1);
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rdyc(w)) ok = 1'b1;
            else st++;
            @(posedge clk); #1;
        end
        setc(w, 32'd0, 1'b0);
        chk("put_accept", 64'(ok), 64'd1);
        last_stalls = st;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        setc(0, 32'd0, 1'b1);
        setc(1, 32'd0, 1'b1);
        setc(2, 32'd0, 1'b1);
        bA.state__D_rdy = 1'b1;
        bB.state__D_rdy = 1'b1;
        bC.state__D_rdy = 1'b1;
        #2;
        chk("rst_vld_a", 64'(bA.state__D_vld), 64'd0);
        chk("rst_d_a",   64'(bA.state__D),     64'd0);
        chk("rst_rdy_a", 64'(bA.state__C_rdy), 64'd0);
        chk("rst_rdy_b", 64'(bB.state__C_rdy), 64'd0);
        chk("rst_rdy_c", 64'(bC.state__C_rdy), 64'd0);
        setc(0, 32'd0, 1'b0);
        setc(1, 32'd0, 1'b0);
        setc(2, 32'd0, 1'b0);
        idle(2);
        rst = 1'b1;
        idle(1);

        // basic frame
        qa.push_back(64'd10);
        for (int i = 1; i <= 4; i++) begin
            put(0, 32'(i));
            chk("basic_stall", 64'(last_stalls), 64'd0);
        end
        chk("basic_vld", 64'(bA.state__D_vld), 64'd1);
        chk("basic_d",   64'(bA.state__D),     64'd10);
        @(negedge clk);
        @(negedge clk);
        chk("basic_one_cycle", 64'(bA.state__D_vld), 64'd0);
        idle(1);

        // wrap at default width and at 32 bits
        qa.push_back(64'h3_FFFF_FFFC);
        repeat (4) put(0, 32'hFFFF_FFFF);
        chk("wrap34_d", 64'(bA.state__D), 64'h3_FFFF_FFFC);
        qb.push_back(64'd0);
        put(1, 32'hFFFF_FFFF);
        put(1, 32'd1);
        put(1, 32'd0);
        put(1, 32'd0);
        chk("wrap32_vld", 64'(bB.state__D_vld), 64'd1);
        chk("wrap32_d",   64'(bB.state__D),     64'd0);
        idle(3);

        // backpressure
        bA.state__D_rdy = 1'b0;
        qa.push_back(64'd10);
        qa.push_back(64'd20);
        for (int i = 1; i <= 4; i++) put(0, 32'(i));
        for (int i = 0; i < 3; i++) begin
            put(0, 32'd5);
            chk("bp_early_stall", 64'(last_stalls), 64'd0);
        end
        setc(0, 32'd5, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_last_stall", 64'(bA.state__C_rdy), 64'd0);
            chk("bp_hold_vld",   64'(bA.state__D_vld), 64'd1);
            chk("bp_hold_d",     64'(bA.state__D),     64'd10);
            @(posedge clk); #1;
        end
        bA.state__D_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 64'(bA.state__C_rdy), 64'd1);
        @(posedge clk); #1;
        setc(0, 32'd0, 1'b0);
        chk("bp_b2b_vld", 64'(bA.state__D_vld), 64'd1);
        chk("bp_b2b_d",   64'(bA.state__D),     64'd20);
        idle(3);

        // clear discards the partial frame
        put(0, 32'd7);
        put(0, 32'd7);
        setc(0, 32'd7, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        chk("clear_rdy", 64'(bA.state__C_rdy), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        setc(0, 32'd0, 1'b0);
        qa.push_back(64'd4);
        repeat (4) put(0, 32'd1);
        chk("clear_d", 64'(bA.state__D), 64'd4);
        idle(3);

        // async reset mid-frame
        repeat (3) put(0, 32'd3);
        setc(0, 32'd3, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_vld", 64'(bA.state__D_vld), 64'd0);
        chk("arst_rdy", 64'(bA.state__C_rdy), 64'd0);
        idle(2);
        setc(0, 32'd0, 1'b0);
        rst = 1'b1;
        qa.push_back(64'd8);
        repeat (4) put(0, 32'd2);
        chk("arst_d", 64'(bA.state__D), 64'd8);
        idle(3);

        // N=1 pass-through
        qc.push_back(64'd9);
        qc.push_back(64'h0_FFFF_FFFF);
        qc.push_back(64'd3);
        put(2, 32'd9);
        chk("n1_stall0", 64'(last_stalls), 64'd0);
        chk("n1_d0", 64'(bC.state__D), 64'd9);
        put(2, 32'hFFFF_FFFF);
        chk("n1_stall1", 64'(last_stalls), 64'd0);
        chk("n1_d1", 64'(bC.state__D), 64'h0_FFFF_FFFF);
        put(2, 32'd3);
        chk("n1_stall2", 64'(last_stalls), 64'd0);
        chk("n1_d2", 64'(bC.state__D), 64'd3);
        chk("n1_vld", 64'(bC.state__D_vld), 64'd1);
        idle(4);

        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        chk("qc_empty", 64'(qc.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_accumulate.md
# frame_accumulate

Streaming frame accumulator that sits directly downstream of the 32-bit `add` stage and consumes its `state__C` sum channel. It adds every `N` consecutive accepted samples into one frame total and emits that total on a registered `state__D` output channel. Full throughput is one sample per cycle. Handshakes follow the codebase's valid/ready channel convention.

## Interface

Parameters:
- `N`, default 4: samples per frame; legal range 1..256.
- `OUT_W`, default 34: width of the frame total; legal range 32..64. The total is computed modulo 2^OUT_W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion (0) immediately clears all state; deassertion is synchronized externally.
- `state__C`  in  32  sample from the upstream adder.
- `state__C_vld`  in  1  sample valid.
- `state__C_rdy`  out  1  sample accepted this cycle. Asserted only when `state__C_vld` is high and the block can take the sample.
- `clear`  in  1  synchronous pulse; discards the partial frame in progress.
- `state__D`  out  OUT_W  registered frame total.
- `state__D_vld`  out  1  registered; frame total valid.
- `state__D_rdy`  in  1  downstream ready.

## Operation

- Internal state:
  - `acc` (OUT_W bits): running partial sum.
  - `cnt` (8 bits, 0..N-1): samples in the current frame.
  - `d_reg` / `d_vld_reg`: output register and its valid flag.
- The output register is free this cycle when `~d_vld_reg | state__D_rdy`.
- Sample acceptance: `state__C_rdy = state__C_vld & ~clear & (cnt != N-1 | out_free)`. A transfer occurs when `state__C_rdy` is 1.
- Accept with `cnt < N-1`:
  - `acc <= acc + zero_extend(state__C)`, modulo 2^OUT_W.
  - `cnt <= cnt + 1`.
- Accept with `cnt == N-1` (last sample of the frame):
  - `d_reg <= acc + zero_extend(state__C)`.
  - `d_vld_reg <= 1`.
  - `acc <= 0`, `cnt <= 0`.
- Output drain: if `d_vld_reg & state__D_rdy` and no last-sample accept occurs that cycle, then `d_vld_reg <= 0`.
  - A drain and a last-sample accept in the same cycle load the new total with valid held at 1. This gives back-to-back frames without a bubble.
- `clear`:
  - Has priority over acceptance; `state__C_rdy` is 0 that cycle.
  - `acc <= 0`, `cnt <= 0`.
  - Does not touch `d_reg` / `d_vld_reg`; a pending total still drains normally.
- `N == 1`: every accepted sample is a last sample, so the block behaves as a one-deep registered pass-through that zero-extends each sample.
- `state__D_vld` never depends combinationally on `state__D_rdy`. `state__C_rdy` depends combinationally on `state__C_vld`, `clear` and `state__D_rdy`.

## Timing

- Reset (`rst` = 0) values:
  - `acc`, `cnt`, `d_reg` all 0.
  - `d_vld_reg` = 0, so `state__D` = 0 and `state__D_vld` = 0.
  - `state__C_rdy` is forced to 0 while reset is asserted.
- Latency: a last sample accepted at edge t drives `state__D_vld` = 1 and a valid `state__D` from just after edge t. The upstream adder's output register feeds this block with zero additional bubbles.
- Throughput is 1 sample per cycle while `state__D_rdy` is 1 at each frame boundary.
- Backpressure:
  - Only the last sample of a frame stalls; samples 1..N-1 of the next frame are still accepted while a total is pending.
  - `state__D` and `state__D_vld` hold stable until the total is transferred.
- Reset mid-frame: the partial sum and any pending total are lost. There is no output glitch beyond valid dropping to 0 asynchronously.
- Arithmetic: unsigned. The maximum exact total is N·(2^32−1); overflow beyond OUT_W bits wraps silently.

## Test plan

- Basic frame: N=4, `state__D_rdy`=1, feed 1,2,3,4 back-to-back. Required response: `state__D` = 10 with `state__D_vld` high for exactly one cycle after the 4th accept; `state__C_rdy` is 1 on all four cycles.
- Wrap: OUT_W=32, N=4, feed 0xFFFF_FFFF, 1, 0, 0 → `state__D` = 0. Default OUT_W=34 with four samples of 0xFFFF_FFFF → `state__D` = 0x3_FFFF_FFFC.
- Backpressure:
  - Frame 1 (1,2,3,4) completes with `state__D_rdy`=0, so total 10 is held.
  - Feed frame 2 as 5,5,5,5. The first three 5s are accepted; the 4th stalls with `state__C_rdy`=0.
  - Raise `state__D_rdy`: 10 transfers and the 4th 5 is accepted in the same cycle.
  - Next cycle `state__D` = 20 with valid continuously high.
- Clear: feed 7,7, pulse `clear` while `state__C_vld`=1. Required: `state__C_rdy`=0 that cycle. Then feed 1,1,1,1 → `state__D` = 4.
- Async reset mid-frame: after 3 accepted samples, drive `rst`=0 between edges. Required: `state__D_vld` and `state__C_rdy` go to 0 immediately. After release, four samples of 2 → `state__D` = 8.
- N=1 instance: stream 9, 0xFFFF_FFFF, 3 with `state__D_rdy`=1. Each value appears zero-extended one edge after acceptance with no bubbles.
